// File: rtl/cv32e40p_hwloop_controller.sv
// Hardware-loop controller: matches the ID PC against loop end addresses, issues jump and decrement requests.
// Latency: a match in cycle T is visible on the outputs at T+1. Backpressure: the jump is held until jump_ack_i or flush_i.
// Optional taken-jump counter is enabled by defining CV32E40P_HWLP_JUMP_CNT_EN.
module cv32e40p_hwloop_controller #(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          current_pc_i,
    input  logic                 id_valid_i,
    input  logic [N_REGS*32-1:0] hwlp_start_addr_i,
    input  logic [N_REGS*32-1:0] hwlp_end_addr_i,
    input  logic [N_REGS*32-1:0] hwlp_counter_i,
    input  logic                 jump_ack_i,
    input  logic                 flush_i,
    output logic                 hwlp_jump_o,
    output logic [31:0]          hwlp_targ_addr_o,
    output logic [N_REGS-1:0]    hwlp_dec_cnt_o,
    output logic [31:0]          hwlp_jump_cnt_o
);

    typedef enum logic [1:0] {IDLE, JUMP_PEND, EXIT} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_jump, w_jump_nxt;
    logic [31:0]         r_targ, w_targ_nxt;
    logic [N_REGS-1:0]   r_dec, w_dec_nxt;
    logic                w_any;
    logic [N_REG_BITS-1:0] w_sel;
    logic [31:0]         w_sel_cnt;
    logic [31:0]         w_sel_start;

    // Scan from the highest index down so the innermost (lowest) match wins.
    always_comb begin
        w_any       = 1'b0;
        w_sel       = '0;
        w_sel_cnt   = '0;
        w_sel_start = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (id_valid_i && (current_pc_i == hwlp_end_addr_i[k*32 +: 32]) &&
                (hwlp_counter_i[k*32 +: 32] != 32'd0)) begin
                w_any       = 1'b1;
                w_sel       = N_REG_BITS'(k);
                w_sel_cnt   = hwlp_counter_i[k*32 +: 32];
                w_sel_start = hwlp_start_addr_i[k*32 +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_jump_nxt  = r_jump;
        w_targ_nxt  = r_targ;
        w_dec_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_any && !flush_i) begin
                    w_dec_nxt = N_REGS'(1) << w_sel;
                    if (w_sel_cnt == 32'd1) begin
                        w_state_nxt = EXIT;
                    end else begin
                        w_state_nxt = JUMP_PEND;
                        w_jump_nxt  = 1'b1;
                        w_targ_nxt  = w_sel_start;
                    end
                end
            end
            JUMP_PEND: begin
                if (flush_i || jump_ack_i) begin
                    w_state_nxt = IDLE;
                    w_jump_nxt  = 1'b0;
                end
            end
            // One idle cycle lets the register file apply the last decrement.
            EXIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_jump  <= 1'b0;
            r_targ  <= '0;
            r_dec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_jump  <= w_jump_nxt;
            r_targ  <= w_targ_nxt;
            r_dec   <= w_dec_nxt;
        end
    end

    assign hwlp_jump_o      = r_jump;
    assign hwlp_targ_addr_o = r_targ;
    assign hwlp_dec_cnt_o   = r_dec;

`ifdef CV32E40P_HWLP_JUMP_CNT_EN
    logic [31:0] r_jump_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = (r_state == JUMP_PEND) && jump_ack_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_jump_cnt <= '0;
        end else if (w_cnt_inc && (r_jump_cnt != 32'hFFFF_FFFF)) begin
            r_jump_cnt <= r_jump_cnt + 32'd1;
        end
    end

    assign hwlp_jump_cnt_o = r_jump_cnt;
`else
    assign hwlp_jump_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_controller.sv
// Bench for cv32e40p_hwloop_controller: directed scenarios plus a randomized run against a behavioural model.
module tb_cv32e40p_hwloop_controller;

    localparam int N = 2;
`ifdef CV32E40P_HWLP_JUMP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     current_pc_i;
    logic            id_valid_i;
    logic [N*32-1:0] hwlp_start_addr_i;
    logic [N*32-1:0] hwlp_end_addr_i;
    logic [N*32-1:0] hwlp_counter_i;
    logic            jump_ack_i;
    logic            flush_i;
    logic            hwlp_jump_o;
    logic [31:0]     hwlp_targ_addr_o;
    logic [N-1:0]    hwlp_dec_cnt_o;
    logic [31:0]     hwlp_jump_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int dir_acks = 0;

    always #5 clk = ~clk;

    cv32e40p_hwloop_controller #(.N_REGS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .current_pc_i      (current_pc_i),
        .id_valid_i        (id_valid_i),
        .hwlp_start_addr_i (hwlp_start_addr_i),
        .hwlp_end_addr_i   (hwlp_end_addr_i),
        .hwlp_counter_i    (hwlp_counter_i),
        .jump_ack_i        (jump_ack_i),
        .flush_i           (flush_i),
        .hwlp_jump_o       (hwlp_jump_o),
        .hwlp_targ_addr_o  (hwlp_targ_addr_o),
        .hwlp_dec_cnt_o    (hwlp_dec_cnt_o),
        .hwlp_jump_cnt_o   (hwlp_jump_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_loop(input int k, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        hwlp_start_addr_i[k*32 +: 32] = s;
        hwlp_end_addr_i[k*32 +: 32]   = e;
        hwlp_counter_i[k*32 +: 32]    = c;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_valid_i = 1'b0; jump_ack_i = 1'b0; flush_i = 1'b0;
        current_pc_i = '0; hwlp_start_addr_i = '0; hwlp_end_addr_i = '0; hwlp_counter_i = '0;
        tick(); tick();
        rst = 1'b0;
        dir_acks = 0;
        n_checks++;
        if ({hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o, hwlp_jump_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: jump=%b targ=%h dec=%b cnt=%0d, required all zero",
                     hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o, hwlp_jump_cnt_o);
        end
    endtask

    task automatic test_basic_jump();
        set_loop(0, 32'h80, 32'h100, 32'd3);
        set_loop(1, 32'h900, 32'h999, 32'd0);
        current_pc_i = 32'h100; id_valid_i = 1'b1;
        tick();
        id_valid_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_targ_addr_o !== 32'h80 || hwlp_dec_cnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_issue: jump=%b targ=%h dec=%b, required 1 00000080 01",
                     hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o);
        end
        tick();
        n_checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_targ_addr_o !== 32'h80 || hwlp_dec_cnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_hold: jump=%b targ=%h dec=%b, required 1 00000080 00",
                     hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o);
        end
        // Ack together with a fresh match: the match must be ignored.
        jump_ack_i = 1'b1; id_valid_i = 1'b1;
        tick();
        jump_ack_i = 1'b0; id_valid_i = 1'b0; dir_acks++;
        n_checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_dec_cnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_ack: jump=%b dec=%b, required 0 00", hwlp_jump_o, hwlp_dec_cnt_o);
        end
    endtask

    task automatic test_last_iter();
        set_loop(0, 32'h80, 32'h100, 32'd1);
        current_pc_i = 32'h100; id_valid_i = 1'b1;
        tick();
        n_checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_dec_cnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL last_iter_dec: jump=%b dec=%b, required 0 01", hwlp_jump_o, hwlp_dec_cnt_o);
        end
        tick();
        n_checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_dec_cnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL last_iter_exit: jump=%b dec=%b, required 0 00", hwlp_jump_o, hwlp_dec_cnt_o);
        end
        tick();
        id_valid_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_dec_cnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL last_iter_rematch: jump=%b dec=%b, required 0 01", hwlp_jump_o, hwlp_dec_cnt_o);
        end
        tick();
    endtask

    task automatic test_nested();
        set_loop(0, 32'h40, 32'h200, 32'd5);
        set_loop(1, 32'h60, 32'h200, 32'd7);
        current_pc_i = 32'h200; id_valid_i = 1'b1;
        tick();
        id_valid_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_targ_addr_o !== 32'h40 || hwlp_dec_cnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL nested: jump=%b targ=%h dec=%b, required 1 00000040 01",
                     hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o);
        end
        jump_ack_i = 1'b1; tick(); jump_ack_i = 1'b0; dir_acks++;
    endtask

    task automatic test_skip_zero();
        set_loop(0, 32'h40, 32'h200, 32'd0);
        set_loop(1, 32'h60, 32'h200, 32'd2);
        current_pc_i = 32'h200; id_valid_i = 1'b1;
        tick();
        id_valid_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_targ_addr_o !== 32'h60 || hwlp_dec_cnt_o !== 2'b10) begin
            n_fail++;
            $display("FAIL skip_zero: jump=%b targ=%h dec=%b, required 1 00000060 10",
                     hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o);
        end
        jump_ack_i = 1'b1; tick(); jump_ack_i = 1'b0; dir_acks++;
    endtask

    task automatic test_flush();
        set_loop(0, 32'h80, 32'h100, 32'hFFFF_FFFF);
        set_loop(1, 32'h60, 32'h300, 32'd0);
        current_pc_i = 32'h100; id_valid_i = 1'b1;
        tick();
        id_valid_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_dec_cnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL max_count_jump: jump=%b dec=%b, required 1 01", hwlp_jump_o, hwlp_dec_cnt_o);
        end
        flush_i = 1'b1; jump_ack_i = 1'b1;
        tick();
        flush_i = 1'b0; jump_ack_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_jump_cnt_o !== (CNT_EN ? 32'(dir_acks) : 32'd0)) begin
            n_fail++;
            $display("FAIL flush_ack: jump=%b cnt=%0d, required 0 %0d",
                     hwlp_jump_o, hwlp_jump_cnt_o, CNT_EN ? dir_acks : 0);
        end
        // Back in IDLE: a match is accepted immediately.
        id_valid_i = 1'b1;
        tick();
        n_checks++;
        if (hwlp_jump_o !== 1'b1 || hwlp_dec_cnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_idle: jump=%b dec=%b, required 1 01", hwlp_jump_o, hwlp_dec_cnt_o);
        end
        flush_i = 1'b1; tick();
        // Flush in IDLE suppresses the match.
        tick();
        id_valid_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (hwlp_jump_o !== 1'b0 || hwlp_dec_cnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_suppress: jump=%b dec=%b, required 0 00", hwlp_jump_o, hwlp_dec_cnt_o);
        end
    endtask

    task automatic test_rst_mid_pend();
        set_loop(0, 32'h84, 32'h100, 32'd9);
        current_pc_i = 32'h100; id_valid_i = 1'b1;
        tick();
        id_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dir_acks = 0;
        n_checks++;
        if ({hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o, hwlp_jump_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_pend: jump=%b targ=%h dec=%b cnt=%0d, required all zero",
                     hwlp_jump_o, hwlp_targ_addr_o, hwlp_dec_cnt_o, hwlp_jump_cnt_o);
        end
    endtask

    task automatic test_jump_cnt();
        set_loop(0, 32'h80, 32'h100, 32'd4);
        current_pc_i = 32'h100;
        for (int i = 0; i < 4; i++) begin
            id_valid_i = 1'b1; tick(); id_valid_i = 1'b0;
            tick();
            jump_ack_i = 1'b1; tick(); jump_ack_i = 1'b0; dir_acks++;
        end
        n_checks++;
        if (hwlp_jump_cnt_o !== (CNT_EN ? 32'd4 : 32'd0)) begin
            n_fail++;
            $display("FAIL jump_cnt: got %0d, required %0d", hwlp_jump_cnt_o, CNT_EN ? 4 : 0);
        end
    endtask

    function automatic logic [31:0] pick_cnt();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'd2;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        // Model: 'pending' = a jump is outstanding, 'gap' = one dead cycle after a final iteration.
        bit          pending = 1'b0;
        bit          gap = 1'b0;
        logic [31:0] m_targ = '0;
        logic [N-1:0] m_dec = '0;
        logic [31:0] m_cnt = '0;
        logic [31:0] ends [N];
        logic [31:0] cnts [N];
        int          hit;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                ends[k] = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h200;
                cnts[k] = pick_cnt();
                set_loop(k, $urandom, ends[k], cnts[k]);
            end
            current_pc_i = ($urandom_range(0, 3) == 0) ? 32'h300 : ends[$urandom_range(0, N-1)];
            id_valid_i   = ($urandom_range(0, 3) != 0);
            jump_ack_i   = ($urandom_range(0, 2) == 0);
            flush_i      = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 99) == 0);

            m_dec = '0;
            if (rst) begin
                pending = 1'b0; gap = 1'b0; m_targ = '0; m_cnt = '0;
            end else if (pending) begin
                if (flush_i) pending = 1'b0;
                else if (jump_ack_i) begin
                    pending = 1'b0;
                    if (CNT_EN && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                end
            end else if (gap) begin
                gap = 1'b0;
            end else if (!flush_i && id_valid_i) begin
                hit = -1;
                for (int k = 0; k < N; k++)
                    if (hit < 0 && current_pc_i == ends[k] && cnts[k] != 0) hit = k;
                if (hit >= 0) begin
                    m_dec[hit] = 1'b1;
                    if (cnts[hit] == 1) gap = 1'b1;
                    else begin
                        pending = 1'b1;
                        m_targ  = hwlp_start_addr_i[hit*32 +: 32];
                    end
                end
            end

            tick();
            n_checks++;
            if (hwlp_jump_o !== pending || hwlp_dec_cnt_o !== m_dec || hwlp_jump_cnt_o !== m_cnt ||
                ((pending || rst) && hwlp_targ_addr_o !== m_targ)) begin
                n_fail++;
                $display("FAIL random cyc %0d: jump=%b dec=%b targ=%h cnt=%0d, required %b %b %h %0d",
                         cyc, hwlp_jump_o, hwlp_dec_cnt_o, hwlp_targ_addr_o, hwlp_jump_cnt_o,
                         pending, m_dec, m_targ, m_cnt);
            end
        end
        rst = 1'b0; id_valid_i = 1'b0; jump_ack_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_jump();
        test_last_iter();
        test_nested();
        test_skip_zero();
        test_flush();
        test_rst_mid_pend();
        test_jump_cnt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_hwloop_controller.md
Name: cv32e40p_hwloop_controller

Overview:
- Downstream consumer of the hardware-loop register file in the ID stage.
- Compares the retiring ID-stage PC against each loop's end address and issues a registered jump request to the start address, holding it until the fetch stage accepts it.
- Drives the per-loop decrement pulses back into the loop register file.
- Loop 0 is the innermost loop and has the highest priority.

Parameters:
- N_REGS, 2, number of hardware loops.
- N_REG_BITS, $clog2(N_REGS), width of a loop index.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- current_pc_i  input  32  PC of the instruction in ID.
- id_valid_i  input  1  instruction in ID retires this cycle.
- hwlp_start_addr_i  input  N_REGS*32  loop start addresses; loop k in bits [k*32 +: 32].
- hwlp_end_addr_i  input  N_REGS*32  loop end addresses, same packing.
- hwlp_counter_i  input  N_REGS*32  loop iteration counters, unsigned, same packing.
- jump_ack_i  input  1  fetch stage accepts the pending jump.
- flush_i  input  1  branch/exception kill from the controller.
- hwlp_jump_o  output  1  jump request to fetch.
- hwlp_targ_addr_o  output  32  jump target.
- hwlp_dec_cnt_o  output  N_REGS  one-hot decrement pulse to the loop register file.
- hwlp_jump_cnt_o  output  32  taken-jump count (optional feature).

Behaviour:
- States: IDLE, JUMP_PEND, EXIT. Reset puts the FSM in IDLE.
- Reset values: hwlp_jump_o=0, hwlp_targ_addr_o=0, hwlp_dec_cnt_o=0, hwlp_jump_cnt_o=0.
- Match for loop k: id_valid_i=1, current_pc_i==end[k] and counter[k]!=0.
- Selected loop: lowest matching k. Higher-index matches in the same cycle are ignored.
- Matches are evaluated only in IDLE; they are ignored in JUMP_PEND and EXIT.
- On a match in cycle T, all outputs below are registered and visible at T+1:
  - hwlp_dec_cnt_o = onehot(k) for exactly one cycle, at T+1, whether or not a jump follows.
  - counter[k]>=2: hwlp_jump_o=1, hwlp_targ_addr_o=start[k], next state JUMP_PEND.
  - counter[k]==1 (last iteration): no jump, next state EXIT.
- JUMP_PEND:
  - hwlp_jump_o and hwlp_targ_addr_o stay stable until the cycle in which jump_ack_i=1.
  - On ack: next state IDLE; hwlp_jump_o=0 from the following cycle.
  - A match in the ack cycle is ignored.
- EXIT: lasts one cycle, then IDLE. This guarantees the loop register file has applied the decrement before the next compare.
- jump_ack_i while not in JUMP_PEND: ignored.
- flush_i=1:
  - In JUMP_PEND: next state IDLE, hwlp_jump_o=0 next cycle.
  - flush_i wins over a simultaneous jump_ack_i; that jump is not counted.
  - An already-issued decrement is not undone.
- flush_i=1 in IDLE: suppresses any match in that cycle.
- rst asserted in any state: FSM returns to IDLE and all outputs return to reset values at the next edge, including mid-JUMP_PEND.
- Counter comparisons are 32-bit unsigned; 0xFFFFFFFF counts as >=2.
- No arithmetic on counters inside this block; the decrement is done by the loop register file.

Optional Feature:
- Macro: CV32E40P_HWLP_JUMP_CNT_EN.
- Defined: a 32-bit register increments on every cycle in which the FSM is in JUMP_PEND and jump_ack_i=1 and flush_i=0.
  - It saturates at 0xFFFFFFFF.
  - It is cleared by rst.
  - It drives hwlp_jump_cnt_o.
- Undefined: hwlp_jump_cnt_o is tied to 0 and no counter register exists.

Test Plan:
- end0=0x100, start0=0x80, cnt0=3, pc=0x100, id_valid pulse at T -> T+1: jump=1, targ=0x80, dec_cnt=2'b01 for one cycle; ack at T+3 -> jump=0 at T+4.
- cnt0=1, pc=end0 -> dec_cnt=2'b01 at T+1, jump=0 throughout; a second match at T+1 is ignored (EXIT); a match at T+2 is accepted.
- Nested: end0=end1=0x200, cnt0=5, cnt1=7 -> only loop 0 selected, dec_cnt=2'b01, targ=start0.
- cnt0=0, cnt1=2, pc=end0=end1 -> loop 1 selected, dec_cnt=2'b10, targ=start1.
- JUMP_PEND with flush and ack in the same cycle -> jump=0 next cycle, FSM in IDLE, jump_cnt unchanged (macro defined); rst mid-JUMP_PEND -> all outputs 0 next cycle.
- Macro defined: 4 acked jumps -> hwlp_jump_cnt_o=4; macro undefined -> stays 0.
